// File: rtl/mem_pkg.sv
// Definitions shared by the memory-control decode stage and the load-response unit.
package mem_pkg;

  typedef logic [8:0] ext_type_t;

  // Bit positions within ext_type_t, listed MSB first as {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr}
  localparam int EXT_LB  = 8;
  localparam int EXT_LBU = 7;
  localparam int EXT_LH  = 6;
  localparam int EXT_LHU = 5;
  localparam int EXT_LW  = 4;
  localparam int EXT_LWL = 3;
  localparam int EXT_LWR = 2;
  localparam int EXT_SWL = 1;
  localparam int EXT_SWR = 0;

  typedef struct packed {
    ext_type_t   ext;
    logic [1:0]  off;
    logic [31:0] rt_old;
    logic [4:0]  dest;
    logic        kill;
  } load_meta_t;

endpackage

// File: rtl/load_extract.sv
// Pure-combinational byte/half extraction, sign/zero extension and lwl/lwr merge of a read word.
module load_extract
  import mem_pkg::*;
(
  input  ext_type_t   ext,
  input  logic [1:0]  off,
  input  logic [31:0] rt_old,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0] shr_s;
  logic [15:0] half_s;
  logic [2:0]  off_p1_s;
  logic [31:0] lwl_s;
  logic [31:0] lwr_s;
  logic        unused_store_bits_s;

  assign unused_store_bits_s = ext[EXT_SWL] ^ ext[EXT_SWR];

  // Shifted/merged candidates; a 6-bit shift amount of 32 clears the lwl mask at off = 3
  always_comb begin
    shr_s    = rdata >> {off, 3'b000};
    half_s   = off[1] ? rdata[31:16] : rdata[15:0];
    off_p1_s = {1'b0, off} + 3'd1;
    lwl_s    = (rdata << {~off, 3'b000}) | (rt_old & (32'hFFFF_FFFF >> {off_p1_s, 3'b000}));
    lwr_s    = shr_s | (rt_old & ~(32'hFFFF_FFFF >> {off, 3'b000}));
  end

  // Select by load type; anything not exactly one-hot falls back to a plain word load
  always_comb begin
    result = rdata;
    case (ext[EXT_LB:EXT_LWR])
      7'b100_0000: result = {{24{shr_s[7]}}, shr_s[7:0]};
      7'b010_0000: result = {24'd0, shr_s[7:0]};
      7'b001_0000: result = {{16{half_s[15]}}, half_s};
      7'b000_1000: result = {16'd0, half_s};
      7'b000_0100: result = rdata;
      7'b000_0010: result = lwl_s;
      7'b000_0001: result = lwr_s;
      default:     result = rdata;
    endcase
  end

endmodule

// File: rtl/load_resp_unit.sv
// In-order queue of issued-load metadata; pops on each read response and registers the writeback.
module load_resp_unit
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  ext_type_t                  req_ext_type,
  input  logic [1:0]                 req_offset,
  input  logic [31:0]                req_rt_old,
  input  logic [4:0]                 req_dest,
  input  logic                       flush,
  input  logic                       rdata_valid,
  output logic                       rdata_ready,
  input  logic [31:0]                rdata,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [31:0]                wb_data,
  output logic [4:0]                 wb_dest,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  load_meta_t    meta_q [DEPTH];
  load_meta_t    meta_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wb_valid_q, wb_valid_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    wb_dest_q, wb_dest_d;

  load_meta_t    head_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   result_s;

  assign head_s      = meta_q[rd_ptr_q];
  assign req_ready   = (count_q != DEPTH_C);
  assign rdata_ready = (count_q != '0) && (!wb_valid_q || wb_ready || head_s.kill);
  assign push_s      = req_valid && req_ready;
  assign pop_s       = rdata_valid && rdata_ready;

  load_extract u_extract (
    .ext    (head_s.ext),
    .off    (head_s.off),
    .rt_old (head_s.rt_old),
    .rdata  (rdata),
    .result (result_s)
  );

  // Queue contents and pointers; kill is set on every slot because a push always rewrites it
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      meta_d[i] = meta_q[i];
      if (flush) begin
        meta_d[i].kill = 1'b1;
      end else begin
        meta_d[i].kill = meta_q[i].kill;
      end
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      meta_d[wr_ptr_q] = '{ext: req_ext_type, off: req_offset, rt_old: req_rt_old,
                           dest: req_dest, kill: flush};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Occupancy tracks push/pop so full and empty stay distinguishable after pointer wrap
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Writeback register: flush wins over a same-cycle live load
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_dest_d  = wb_dest_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (pop_s && !head_s.kill) begin
      wb_valid_d = 1'b1;
      wb_data_d  = result_s;
      wb_dest_d  = head_s.dest;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_dest_q  <= 5'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= meta_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_dest_q  <= wb_dest_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_dest  = wb_dest_q;
  assign pending  = count_q;

endmodule
